sd_block_responder: RTL
=======================

Name: sd_block_responder

Overview:
- Host-side end of the virtual-disk block protocol that the core's disk clients (HDD controller, floppy_track units) initiate.
- Services sd_rd/sd_wr requests by driving sd_ack, sd_buff_addr, sd_buff_dout and sd_buff_wr, and sampling sd_buff_din.
- Moves each 512-byte block to or from a byte-wide backing store.
- Also emits mount strobes (img_mounted / img_size / img_readonly).
- Used as the simulation and standalone stand-in for the HPS disk service.

Parameters:
- VDNUM, 3, number of virtual disk units.
- MEM_AW, 32, backing-store byte address width.
- UNIT_SHIFT, 26, log2 byte stride between unit images; unit base = idx << UNIT_SHIFT.
- ACK_DELAY, 4, cycles from request capture to sd_ack rise (1..255).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sd_lba  in  VDNUM*32  per-unit block address, unit i at [32i+31:32i].
- sd_rd  in  VDNUM  per-unit read request (disk -> client buffer).
- sd_wr  in  VDNUM  per-unit write request (client buffer -> disk).
- sd_ack  out  VDNUM  per-unit transfer acknowledge.
- sd_buff_addr  out  9  byte index within block.
- sd_buff_dout  out  8  read data to client.
- sd_buff_wr  out  1  read-data strobe.
- sd_buff_din  in  VDNUM*8  per-unit write data from client buffer.
- cfg_mount_stb  in  1  mount/eject command strobe.
- cfg_unit  in  2  unit index for the command.
- cfg_size  in  64  image size in bytes; 0 = eject.
- cfg_ro  in  1  read-only flag for the command.
- img_mounted  out  VDNUM  one-cycle mount pulse per unit.
- img_size  out  64  latched size of the last command.
- img_readonly  out  1  latched read-only flag of the last command.
- mem_addr  out  MEM_AW  backing-store address.
- mem_rd  out  1  backing-store read request.
- mem_wr  out  1  backing-store write request.
- mem_dout  out  8  backing-store write data.
- mem_din  in  8  backing-store read data, valid when mem_ready=1.
- mem_ready  in  1  completes the current mem_rd/mem_wr.
- busy  out  1  transfer in progress.
- wr_reject  out  16  count of writes discarded on read-only units (saturating).

Behaviour:
- Clock and reset: one clock, clk_sys. reset_n is asynchronous and active-low.
- Reset values: all outputs 0. FSM returns to IDLE. Per-unit ro flags clear. Reset mid-transfer abandons it with no further memory access.
- Mount: cfg_mount_stb with cfg_unit<VDNUM latches img_size, img_readonly and ro[unit] on the next edge, and pulses img_mounted[unit] for exactly 1 cycle. cfg_unit>=VDNUM is ignored. A strobe during a transfer is accepted; ro takes effect only for the next transfer.
- FSM states: IDLE, ACK_DLY, RD_FETCH, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_STORE, DONE.
- IDLE:
  - Selects the lowest index i with sd_rd[i]|sd_wr[i].
  - Latches idx and lba = sd_lba[i]. Op = write if sd_wr[i], else read; write wins if both are set.
  - Goes to ACK_DLY with byte counter n=0.
- ACK_DLY: counts ACK_DELAY cycles, then raises sd_ack[idx]. sd_ack[idx] stays high until DONE.
- Address rule: mem_addr = (idx<<UNIT_SHIFT) + (lba<<9) + n, truncated to MEM_AW bits.
- Read path:
  - RD_FETCH holds mem_rd=1 until mem_ready.
  - RD_PUSH then drives sd_buff_addr=n, sd_buff_dout=mem_din (registered) and sd_buff_wr=1 for exactly 1 cycle.
  - n increments. After n=511 go to DONE, else back to RD_FETCH.
- Write path:
  - WR_ADDR drives sd_buff_addr=n for 1 cycle.
  - WR_SAMPLE captures sd_buff_din[idx] on its edge (client RAM has 1-cycle latency; sd_buff_addr is held through both cycles).
  - WR_STORE holds mem_wr=1 with mem_dout=captured byte until mem_ready.
  - If ro[idx]=1, WR_STORE issues no mem_wr and advances immediately.
  - n increments. After n=511 go to DONE.
- DONE: drops sd_ack[idx], increments wr_reject (saturating at 16'hFFFF) if this was a rejected write, then returns to IDLE after 1 cycle. The same unit is re-accepted only on a later cycle with a request still high.
- busy = (state != IDLE).
- sd_buff_wr is never asserted during writes.
- sd_ack has at most one bit set at a time.
- Requests arriving for other units while busy wait in IDLE priority order. Request deassertion after ack rise is normal; no abort exists.

Test Plan:
- Read: memory preloaded with byte(k)=k[7:0] at base of unit 0, LBA 0; pulse sd_rd=3'b001 -> sd_ack[0] rises 4 cycles after capture; exactly 512 sd_buff_wr pulses with addr 0..511 and dout 00..FF repeating; sd_ack[0] falls; busy=0.
- Write: client RAM holds ~k, sd_wr[1]=1, lba=2 -> mem writes at (1<<26)+1024+k with data ~k[7:0] for all k; exactly 512 mem_wr handshakes; no sd_buff_wr.
- Read-only: mount unit 2 with cfg_ro=1, then write -> zero mem_wr, sd_ack cycle completes, wr_reject=1.
- Priority and both-set: sd_rd=3'b110 together with sd_wr[1]=1 -> unit 1 serviced first as a write, then unit 2 read; sd_ack never has two bits set.
- Stalls: mem_ready held low 10 cycles per access -> data is correct and sd_ack stays high throughout.
- Reset: reset_n pulsed low at byte 100 of a read -> sd_ack, busy and mem_rd go to 0 immediately; a new request after release is serviced from n=0.

Source files
------------

// File: rtl/sd_block_responder.sv
// sd_block_responder: host-side end of the virtual-disk block protocol, moving 512-byte
// blocks between the requesting unit's buffer and a byte-wide backing store.
module sd_block_responder #(
    parameter int VDNUM      = 3,
    parameter int MEM_AW     = 32,
    parameter int UNIT_SHIFT = 26,
    parameter int ACK_DELAY  = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [VDNUM*32-1:0] sd_lba,
    input  logic [VDNUM-1:0]    sd_rd,
    input  logic [VDNUM-1:0]    sd_wr,
    output logic [VDNUM-1:0]    sd_ack,
    output logic [8:0]          sd_buff_addr,
    output logic [7:0]          sd_buff_dout,
    output logic                sd_buff_wr,
    input  logic [VDNUM*8-1:0]  sd_buff_din,
    input  logic                cfg_mount_stb,
    input  logic [1:0]          cfg_unit,
    input  logic [63:0]         cfg_size,
    input  logic                cfg_ro,
    output logic [VDNUM-1:0]    img_mounted,
    output logic [63:0]         img_size,
    output logic                img_readonly,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [7:0]          mem_dout,
    input  logic [7:0]          mem_din,
    input  logic                mem_ready,
    output logic                busy,
    output logic [15:0]         wr_reject
);
    localparam int IW = VDNUM > 1 ? $clog2(VDNUM) : 1;

    typedef enum logic [2:0] {IDLE, ACK_DLY, RD_FETCH, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_STORE, DONE} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idx, sel;
    logic hit, op_wr, ro_x, adv;
    logic [31:0] lba;
    logic [VDNUM-1:0] ro;
    logic [8:0] n;
    logic [7:0] dly, data;

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = VDNUM - 1; i >= 0; i--)
            if (sd_rd[i] | sd_wr[i]) begin
                sel = IW'(i);
                hit = 1'b1;
            end
    end

    // ro_x is the read-only state sampled at capture, so a mid-transfer mount only affects later transfers
    assign adv = state == RD_PUSH || (state == WR_STORE && (ro_x || mem_ready));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = hit ? ACK_DLY : IDLE;
            ACK_DLY:   state_nx = dly == 8'(ACK_DELAY - 1) ? (op_wr ? WR_ADDR : RD_FETCH) : ACK_DLY;
            RD_FETCH:  state_nx = mem_ready ? RD_PUSH : RD_FETCH;
            RD_PUSH:   state_nx = n == 9'd511 ? DONE : RD_FETCH;
            WR_ADDR:   state_nx = WR_SAMPLE;
            WR_SAMPLE: state_nx = WR_STORE;
            WR_STORE:  state_nx = adv ? (n == 9'd511 ? DONE : WR_ADDR) : WR_STORE;
            default:   state_nx = IDLE;
        endcase
    end

    assign busy         = state != IDLE;
    assign mem_rd       = state == RD_FETCH;
    assign mem_wr       = state == WR_STORE && !ro_x;
    assign sd_buff_wr   = state == RD_PUSH;
    assign sd_buff_addr = n;
    assign sd_buff_dout = data;
    assign mem_dout     = data;
    assign sd_ack       = (state inside {RD_FETCH, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_STORE}) ? VDNUM'(1) << idx : '0;
    assign mem_addr     = (MEM_AW'(idx) << UNIT_SHIFT) + MEM_AW'({lba, 9'd0}) + MEM_AW'(n);

    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            lba       <= '0;
            op_wr     <= 1'b0;
            ro_x      <= 1'b0;
            n         <= '0;
            dly       <= '0;
            data      <= '0;
            wr_reject <= '0;
        end else begin
            if (state == IDLE && hit) begin
                idx   <= sel;
                lba   <= sd_lba[32*sel +: 32];
                op_wr <= sd_wr[sel];
                ro_x  <= ro[sel];
                n     <= '0;
                dly   <= '0;
            end
            if (state == ACK_DLY)
                dly <= dly + 8'd1;
            if (state == RD_FETCH && mem_ready)
                data <= mem_din;
            if (state == WR_SAMPLE)
                data <= sd_buff_din[8*idx +: 8];
            if (adv)
                n <= n + 9'd1;
            if (state == DONE && op_wr && ro_x && wr_reject != 16'hFFFF)
                wr_reject <= wr_reject + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            img_mounted  <= '0;
            img_size     <= '0;
            img_readonly <= 1'b0;
            ro           <= '0;
        end else begin
            img_mounted <= '0;
            if (cfg_mount_stb && 32'(cfg_unit) < VDNUM) begin
                img_size                     <= cfg_size;
                img_readonly                 <= cfg_ro;
                ro[cfg_unit[IW-1:0]]          <= cfg_ro;
                img_mounted[cfg_unit[IW-1:0]] <= 1'b1;
            end
        end
    end
endmodule
